// File: rtl/mc_main_controller.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back, drives all datapath enables and counts retired instructions.
module mc_main_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             is_jr,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond_eq,
  output logic             pc_write_cond_ne,
  output logic [1:0]       pc_src,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  state_t state_q;
  state_t next_state;
  logic   retire;
  logic   set_illegal;

  assign state = state_q;

  always_comb begin
    next_state  = state_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    case (state_q)
      S_FETCH:     if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:        next_state = S_R_EXEC;
          OP_LW, OP_SW:    next_state = S_MEM_ADDR;
          OP_ADDI, OP_SLTI: next_state = S_I_EXEC;
          OP_BEQ, OP_BNE:  next_state = S_BRANCH;
          OP_J:            next_state = S_JUMP;
          OP_JAL:          next_state = S_JAL;
          default: begin
            next_state  = S_FETCH;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) next_state = S_MEM_WB;
      S_MEM_WRITE: begin
        if (mem_ready) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_R_EXEC: begin
        if (is_jr) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end else begin
          next_state = S_R_WB;
        end
      end
      S_I_EXEC:    next_state = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      default:     next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      instr_count <= '0;
      illegal_op  <= 1'b0;
    end else begin
      state_q <= next_state;
      if (retire)      instr_count <= instr_count + CNT_W'(1);
      if (set_illegal) illegal_op  <= 1'b1;
    end
  end

  // Control decode; everything is held low while reset is asserted so no write escapes.
  always_comb begin
    pc_write         = 1'b0;
    pc_write_cond_eq = 1'b0;
    pc_write_cond_ne = 1'b0;
    pc_src           = 2'b00;
    i_or_d           = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_write         = 1'b0;
    reg_write        = 1'b0;
    reg_dst          = 2'b00;
    mem_to_reg       = 2'b00;
    alu_src_a        = 1'b0;
    alu_src_b        = 2'b00;
    alu_op           = 2'b00;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = 2'b11;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          if (is_jr) begin
            pc_write = 1'b1;
            pc_src   = 2'b11;
          end
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = (opcode == OP_SLTI) ? 2'b11 : 2'b00;
        end
        S_I_WB:     reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a        = 1'b1;
          alu_op           = 2'b01;
          pc_src           = 2'b01;
          pc_write_cond_eq = (opcode == OP_BEQ);
          pc_write_cond_ne = (opcode == OP_BNE);
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mc_main_controller.md
Name: mc_main_controller

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back from the IR opcode, and waits on a memory-ready handshake. It drives all datapath enables and the 2-bit alu_op consumed by the downstream ALU control decoder. That decoder's is_jr flag comes back in to redirect the PC for jr.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
is_jr  in  1  from ALU control (alu_op==10 and funct==001000)
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond_eq  out  1  PC load if ALU zero (beq)
pc_write_cond_ne  out  1  PC load if ALU not zero (bne)
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],imm26,00}, 11 reg A
i_or_d  out  1  memory address: 0 PC, 1 ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  load IR
reg_write  out  1  register file write
reg_dst  out  2  00 rt, 01 rd, 10 $31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
alu_src_a  out  1  0 PC, 1 reg A
alu_src_b  out  2  00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2
alu_op  out  2  00 add, 01 sub, 10 use funct, 11 slt
state  out  4  current state, debug
instr_count  out  CNT_W  retired instructions
illegal_op  out  1  sticky, set on unknown opcode

Behaviour:
- Moore FSM with one state register. Outputs are decoded from state, plus mem_ready/is_jr where noted. Any output not listed for a state is 0.
- Reset: when rst is sampled high, next state is FETCH, instr_count=0 and illegal_op=0. While rst is high, all control outputs are forced to 0 (no writes). Reset mid-instruction aborts it with no partial writes after the edge.
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_READ, 4 MEM_WB, 5 MEM_WRITE, 6 R_EXEC
  - 7 R_WB, 8 I_EXEC, 9 I_WB, 10 BRANCH, 11 JUMP, 12 JAL
  - 13-15 are unused and go to FETCH next cycle.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; then go to DECODE.
  - While mem_ready=0, stay in FETCH with ir_write=pc_write=0.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Dispatch on opcode:
  - 000000 -> R_EXEC
  - 100011 (lw) and 101011 (sw) -> MEM_ADDR
  - 001000 (addi) and 001010 (slti) -> I_EXEC
  - 000100 (beq) and 000101 (bne) -> BRANCH
  - 000010 (j) -> JUMP
  - 000011 (jal) -> JAL
  - any other opcode -> FETCH, set illegal_op, no count.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready=1, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - If is_jr=1: pc_write=1, pc_src=11 -> FETCH.
  - Else -> R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10; alu_op=00 for addi, 11 for slti -> I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. pc_write_cond_eq=1 for beq, pc_write_cond_ne=1 for bne -> FETCH.
- JUMP: pc_write=1, pc_src=10 -> FETCH.
- JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10 -> FETCH. $31 receives the PC value before this edge, i.e. PC+4.
- Cycle counts with mem_ready always 1:
  - lw 5; sw, R-type, addi, slti 4
  - jr, beq, bne, j, jal 3
  - illegal opcode 2 (no retire)
- instr_count increments by 1 on every transition into FETCH from a terminal state: MEM_WB, MEM_WRITE, R_EXEC with is_jr, R_WB, I_WB, BRANCH, JUMP, JAL. It wraps modulo 2^CNT_W.
- illegal_op clears only on rst.
- mem_write and mem_read are never asserted in the same cycle.

Test Plan:
- lw, mem_ready held 0 for 2 cycles in FETCH and 1 cycle in MEM_READ -> states 0,0,0,1,2,3,3,4,0; ir_write only in the third FETCH cycle; reg_write with mem_to_reg=01 in state 4; instr_count 0->1.
- add (opcode 000000, is_jr=0), mem_ready=1 -> 0,1,6,7,0; alu_op=10 in state 6; reg_write and reg_dst=01 in state 7.
- jr (is_jr=1 in R_EXEC) -> 0,1,6,0; pc_write=1, pc_src=11 in state 6; no reg_write anywhere.
- beq then bne -> state 10 asserts pc_write_cond_eq only, then pc_write_cond_ne only; alu_op=01; each takes 3 cycles.
- jal -> 0,1,12,0; state 12 asserts pc_write, pc_src=10, reg_write, reg_dst=10, mem_to_reg=10.
- Opcode 111111 -> 0,1,0, illegal_op=1, instr_count unchanged. Then rst pulsed during MEM_READ of a lw -> outputs 0 while rst is high, state=0, instr_count=0, illegal_op=0.
